alu_multicycle: RTL



---
 rtl/alu_multicycle_if.sv | 25 ++
 rtl/alu_multicycle.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute-stage controller and alu_multicycle.
// The controller side is master; the ALU side is slave.
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             inp_start;
    logic [3:0]       inp_aluControl;
    logic [WIDTH-1:0] inp_data1;
    logic [WIDTH-1:0] inp_data2;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_resultAlu;
    logic             out_zero;
    logic             out_divz;

    modport master (
        output inp_start, inp_aluControl, inp_data1, inp_data2,
        input  out_busy, out_done, out_resultAlu, out_zero, out_divz
    );

    modport slave (
        input  inp_start, inp_aluControl, inp_data1, inp_data2,
        output out_busy, out_done, out_resultAlu, out_zero, out_divz
    );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked integer ALU: eight single-cycle ops plus shift-add multiply and
// restoring divide that iterate one bit per cycle over a shared 2*WIDTH register.
module alu_multicycle #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic              inp_clk,
    input  logic              inp_rst,
    alu_multicycle_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CNTW-1:0]    cnt;
    logic               sel_upper;   // op 9 / op 11: take the upper half of acc
    logic [WIDTH-1:0]   oper;        // multiplicand for MUL, divisor for DIV
    logic [2*WIDTH-1:0] acc;         // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               divz;

    logic               busy;
    logic               accept;
    logic [CNTW-1:0]    cnt_next;
    logic               last_iter;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_divz;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    assign busy      = (state == S_MUL) || (state == S_DIV);
    assign accept    = bus.inp_start && !busy;
    assign cnt_next  = cnt + 1'b1;
    assign last_iter = (cnt_next == CNTW'(WIDTH));

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        sc_result = '0;
        sc_divz   = 1'b0;
        case (bus.inp_aluControl)
            4'd0:    sc_result = bus.inp_data1 + bus.inp_data2;
            4'd1:    sc_result = bus.inp_data1 - bus.inp_data2;
            4'd2:    sc_result = ~bus.inp_data1;
            4'd3:    sc_result = bus.inp_data1 << bus.inp_data2;
            4'd4:    sc_result = bus.inp_data1 >> bus.inp_data2;
            4'd5:    sc_result = bus.inp_data1 & bus.inp_data2;
            4'd6:    sc_result = bus.inp_data1 | bus.inp_data2;
            4'd7:    sc_result = {{(WIDTH-1){1'b0}}, (bus.inp_data1 < bus.inp_data2)};
            4'd10: begin
                sc_result = '1;
                sc_divz   = 1'b1;
            end
            4'd11: begin
                sc_result = bus.inp_data1;
                sc_divz   = 1'b1;
            end
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        mul_addend  = acc[0] ? oper : '0;
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next    = {mul_sum, acc[WIDTH-1:1]};
        // Restoring step: the remainder never exceeds the divisor, so WIDTH+1 bits suffice.
        div_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial   = div_shifted - {1'b0, oper};
        if (div_shifted >= {1'b0, oper})
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sel_upper <= 1'b0;
            oper      <= '0;
            acc       <= '0;
            result    <= '0;
            zero      <= 1'b1;
            divz      <= 1'b0;
        end else begin
            case (state)
                S_MUL, S_DIV: begin
                    acc <= (state == S_MUL) ? mul_next : div_next;
                    cnt <= cnt_next;
                    if (last_iter) begin
                        state <= S_DONE;
                        if (state == S_MUL) begin
                            result <= sel_upper ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                            zero   <= ((sel_upper ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0]) == '0);
                        end else begin
                            result <= sel_upper ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                            zero   <= ((sel_upper ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0]) == '0);
                        end
                        divz <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        cnt       <= '0;
                        sel_upper <= bus.inp_aluControl[0];
                        if (bus.inp_aluControl == 4'd8 || bus.inp_aluControl == 4'd9) begin
                            oper  <= bus.inp_data1;
                            acc   <= {{WIDTH{1'b0}}, bus.inp_data2};
                            state <= S_MUL;
                        end else if ((bus.inp_aluControl == 4'd10 || bus.inp_aluControl == 4'd11)
                                     && bus.inp_data2 != '0) begin
                            oper  <= bus.inp_data2;
                            acc   <= {{WIDTH{1'b0}}, bus.inp_data1};
                            state <= S_DIV;
                        end else begin
                            result <= sc_result;
                            zero   <= (sc_result == '0);
                            divz   <= sc_divz;
                            state  <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out_busy      = busy;
    assign bus.out_done      = (state == S_DONE);
    assign bus.out_resultAlu = result;
    assign bus.out_zero      = zero;
    assign bus.out_divz      = divz;
endmodule
